piso_10bits_ctrl: RTL and testbench

- Parallel-in serial-out transmitter: the counterpart of the team's 10-bit SIPO receiver.
- Captures a 10-bit word on a load handshake and shifts it out one bit per clock on Sdata.
- Drives a frame strobe (shift_en) that gates the receiver's shift clock enable.
- Pulses done when the frame ends; sits between the parallel data source and the serial link.

---
 rtl/piso_10bits_ctrl.sv | 84 ++++++++
 tb/tb_piso_10bits_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_10bits_ctrl.sv
// Parallel-in serial-out transmitter: captures a word on a load handshake and shifts it out
// one bit per clock, framing it with shift_en and closing it with a one-cycle done pulse.
module piso_10bits_ctrl #(
    parameter int unsigned WIDTH     = 10,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Pdata,
    input  logic             load,
    output logic             ready,
    output logic             Sdata,
    output logic             shift_en,
    output logic             done
);

    localparam int unsigned   CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sdata_q, sdata_d;
    logic             shift_en_q, shift_en_d;
    logic             done_q, done_d;
    logic             accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            sreg_q     <= '0;
            cnt_q      <= '0;
            sdata_q    <= 1'b0;
            shift_en_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            sdata_q    <= sdata_d;
            shift_en_q <= shift_en_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: state_d = load ? StShift : StIdle;
            StShift:        if (cnt_q == LastCnt) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    assign ready  = (state_q != StShift);
    assign accept = ready && load;

    // Output registers are loaded from the next state so they line up with state_q.
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (accept) begin
            sreg_d = Pdata;
            cnt_d  = '0;
        end else if (state_q == StShift) begin
            sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
            cnt_d  = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
        end
        shift_en_d = (state_d == StShift);
        done_d     = (state_d == StDone);
        sdata_d    = shift_en_d & (LSB_FIRST ? sreg_d[0] : sreg_d[WIDTH-1]);
    end

    assign Sdata    = sdata_q;
    assign shift_en = shift_en_q;
    assign done     = done_q;

endmodule

// File: tb/tb_piso_10bits_ctrl.sv
// Directed bench for piso_10bits_ctrl: LSB-first and MSB-first instances, each looped back
// into a simple 10-bit SIPO receiver model.
module tb_piso_10bits_ctrl;

    logic       clk = 1'b0;
    logic       reset, load, load2;
    logic [9:0] pdata, pdata2;
    logic       ready, sdata, shift_en, done;
    logic       ready2, sdata2, shift_en2, done2;
    logic [9:0] rx1, rx2;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    piso_10bits_ctrl #(.WIDTH(10), .LSB_FIRST(1'b1)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .Pdata    (pdata),
        .load     (load),
        .ready    (ready),
        .Sdata    (sdata),
        .shift_en (shift_en),
        .done     (done)
    );

    piso_10bits_ctrl #(.WIDTH(10), .LSB_FIRST(1'b0)) u_dut_msb (
        .clk      (clk),
        .reset    (reset),
        .Pdata    (pdata2),
        .load     (load2),
        .ready    (ready2),
        .Sdata    (sdata2),
        .shift_en (shift_en2),
        .done     (done2)
    );

    // Receiver models: shift on clk while shift_en is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx1 <= '0;
            rx2 <= '0;
        end else begin
            if (shift_en)  rx1 <= {sdata, rx1[9:1]};
            if (shift_en2) rx2 <= {rx2[8:0], sdata2};
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_sdata"},    16'(sdata),    16'd0);
        check({tag, "_shift_en"}, 16'(shift_en), 16'd0);
        check({tag, "_done"},     16'(done),     16'd0);
        check({tag, "_ready"},    16'(ready),    16'd1);
    endtask

    task automatic done_check(input string tag);
        check({tag, "_done"},     16'(done),     16'd1);
        check({tag, "_shift_en"}, 16'(shift_en), 16'd0);
        check({tag, "_sdata"},    16'(sdata),    16'd0);
        check({tag, "_ready"},    16'(ready),    16'd1);
    endtask

    // One LSB-first frame; optionally pulses a busy load with inj_word in frame cycle inject_at.
    task automatic frame(input logic [9:0] word, input int inject_at, input logic [9:0] inj_word);
        pdata = word;
        load  = 1'b1;
        step();
        load  = 1'b0;
        pdata = ~word;
        for (int i = 0; i < 10; i++) begin
            check("frm_sdata",    16'(sdata),    16'(word[i]));
            check("frm_shift_en", 16'(shift_en), 16'd1);
            check("frm_ready",    16'(ready),    16'd0);
            check("frm_done",     16'(done),     16'd0);
            load = (i == inject_at);
            if (i == inject_at) pdata = inj_word;
            step();
        end
        load = 1'b0;
        done_check("frm_end");
        check("frm_rx", 16'(rx1), 16'(word));
        step();
        idle_check("frm_post");
    endtask

    initial begin
        reset  = 1'b1;
        load   = 1'b0;
        load2  = 1'b0;
        pdata  = '0;
        pdata2 = '0;
        step();
        step();
        idle_check("rst");
        check("rst_ready2", 16'(ready2), 16'd1);
        check("rst_sdata2", 16'(sdata2), 16'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            idle_check("idle");
        end

        // Expected stream 1,0,0,1,1,0,0,1,0,1
        frame(10'b1010011001, -1, 10'h000);

        // Back-to-back with load held high.
        pdata = 10'h3FF;
        load  = 1'b1;
        step();
        pdata = 10'h000;
        for (int i = 0; i < 10; i++) begin
            check("b2b1_sdata",    16'(sdata),    16'd1);
            check("b2b1_shift_en", 16'(shift_en), 16'd1);
            step();
        end
        done_check("b2b_gap");
        step();
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("b2b2_sdata",    16'(sdata),    16'd0);
            check("b2b2_shift_en", 16'(shift_en), 16'd1);
            check("b2b2_ready",    16'(ready),    16'd0);
            step();
        end
        done_check("b2b_end");
        step();
        idle_check("b2b_post");

        // Busy load in cycle k+4 must be ignored.
        frame(10'h2AA, 3, 10'h155);
        for (int i = 0; i < 3; i++) begin
            step();
            idle_check("busy_post");
        end

        // Reset mid-frame in cycle k+5.
        pdata = 10'h3A5;
        load  = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_check("rst_mid");
        for (int i = 0; i < 12; i++) begin
            step();
            check("rst_mid_done",     16'(done),     16'd0);
            check("rst_mid_shift_en", 16'(shift_en), 16'd0);
        end

        // Reset and load together: nothing captured.
        reset = 1'b1;
        load  = 1'b1;
        pdata = 10'h3FF;
        step();
        reset = 1'b0;
        load  = 1'b0;
        idle_check("rst_load");
        step();
        idle_check("rst_load_next");

        // Loopback words.
        frame(10'h0F3, -1, 10'h000);
        frame(10'h201, -1, 10'h000);
        frame(10'h1C4, -1, 10'h000);

        // MSB-first instance.
        pdata2 = 10'b1000000000;
        load2  = 1'b1;
        step();
        load2  = 1'b0;
        pdata2 = '0;
        for (int i = 0; i < 10; i++) begin
            check("msb_sdata",    16'(sdata2),    (i == 0) ? 16'd1 : 16'd0);
            check("msb_shift_en", 16'(shift_en2), 16'd1);
            check("msb_ready",    16'(ready2),    16'd0);
            step();
        end
        check("msb_done",     16'(done2),     16'd1);
        check("msb_shift_off", 16'(shift_en2), 16'd0);
        check("msb_rx",       16'(rx2),       16'h200);
        step();
        check("msb_done_clr", 16'(done2),     16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
